load_align_unit: RTL and testbench

Parametrised, pipelined load-data alignment stage between the data-memory read port and register-file writeback. It accepts a raw memory word plus load type, byte offset and destination register. It returns the aligned, sign- or zero-extended writeback value with per-byte register write enables, covering partial loads (LWL/LWR) and byte/halfword loads. One registered output stage and one skid entry give full-throughput valid/ready flow control, a synchronous flush, and misalignment detection.

---
 rtl/load_align_unit.sv | 164 ++++++++++++++++
 tb/tb_load_align_unit.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - load-data alignment stage with output register and one skid entry
module load_align_unit #(
  parameter  int DATA_W = 32,
  parameter  int RD_W   = 5,
  localparam int NB     = DATA_W / 8,
  localparam int OFF_W  = $clog2(NB)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_type,
  input  logic [OFF_W-1:0]  in_off,
  input  logic              in_regwr,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [NB-1:0]     out_be,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_misalign
);

  localparam logic [NB-1:0] BE_ALL = '1;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] c_data;
  logic [NB-1:0]     c_be;
  logic              c_mis;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  int                sh_b, sh_h;

  logic [DATA_W-1:0] skid_data;
  logic [NB-1:0]     skid_be;
  logic [RD_W-1:0]   skid_rd;
  logic              skid_mis;

  logic accept, drain;
  logic ld_out_in, ld_out_skid, ld_skid;

  // Big-endian: offset k selects the byte whose LSB sits at 8*(NB-1-k).
  // The halfword index drops in_off[0] so odd (misaligned) offsets never form a negative select.
  always_comb begin
    sh_b   = 8 * (NB - 1 - int'(in_off));
    sh_h   = 8 * (NB - 2 - int'({in_off[OFF_W-1:1], 1'b0}));
    byte_v = in_data[sh_b +: 8];
    half_v = in_data[sh_h +: 16];
    c_data = in_data;
    c_be   = {NB{in_regwr}};
    c_mis  = 1'b0;
    case (in_type)
      3'b001: begin
        c_data = in_data << (8 * int'(in_off));
        c_be   = BE_ALL << in_off;
      end
      3'b010: begin
        c_be = BE_ALL;
        if (in_off != '0) begin
          c_mis = 1'b1;
          c_be  = '0;
        end
      end
      3'b011: begin
        c_data = in_data >> sh_b;
        c_be   = BE_ALL >> (NB - 1 - int'(in_off));
      end
      3'b100, 3'b101: begin
        c_data = {{(DATA_W-8){~in_type[0] & byte_v[7]}}, byte_v};
        c_be   = BE_ALL;
      end
      3'b110, 3'b111: begin
        if (in_off[0]) begin
          c_mis = 1'b1;
          c_be  = '0;
        end else begin
          c_data = {{(DATA_W-16){~in_type[0] & half_v[15]}}, half_v};
          c_be   = BE_ALL;
        end
      end
      default: ;
    endcase
  end

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Flush overrides everything: no loads, occupancy returns to EMPTY.
  always_comb begin
    state_d     = state_q;
    ld_out_in   = 1'b0;
    ld_out_skid = 1'b0;
    ld_skid     = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          ld_out_in = 1'b1;
          state_d   = ONE;
        end
        ONE: begin
          if (accept && drain) begin
            ld_out_in = 1'b1;
          end else if (drain) begin
            state_d = EMPTY;
          end else if (accept) begin
            ld_skid = 1'b1;
            state_d = TWO;
          end
        end
        TWO: if (drain) begin
          ld_out_skid = 1'b1;
          state_d     = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data     <= '0;
      out_be       <= '0;
      out_rd       <= '0;
      out_misalign <= 1'b0;
      skid_data    <= '0;
      skid_be      <= '0;
      skid_rd      <= '0;
      skid_mis     <= 1'b0;
    end else begin
      if (ld_out_in) begin
        out_data     <= c_data;
        out_be       <= c_be;
        out_rd       <= in_rd;
        out_misalign <= c_mis;
      end else if (ld_out_skid) begin
        out_data     <= skid_data;
        out_be       <= skid_be;
        out_rd       <= skid_rd;
        out_misalign <= skid_mis;
      end
      if (ld_skid) begin
        skid_data <= c_data;
        skid_be   <= c_be;
        skid_rd   <= in_rd;
        skid_mis  <= c_mis;
      end
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// tb/tb_load_align_unit.sv - randomized and directed bench for load_align_unit (32- and 64-bit)
module tb_load_align_unit;

  typedef struct packed {
    logic        present;
    logic [63:0] data;
    logic [7:0]  be;
    logic [4:0]  rd;
    logic        mis;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, in_ready, in_regwr, out_valid, out_ready, out_misalign;
  logic [31:0] in_data, out_data;
  logic [2:0]  in_type;
  logic [1:0]  in_off;
  logic [4:0]  in_rd, out_rd;
  logic [3:0]  out_be;

  logic        w_flush, w_in_valid, w_in_ready, w_in_regwr, w_out_valid, w_out_ready, w_out_misalign;
  logic [63:0] w_in_data, w_out_data;
  logic [2:0]  w_in_type;
  logic [2:0]  w_in_off;
  logic [4:0]  w_in_rd, w_out_rd;
  logic [7:0]  w_out_be;

  int n_checks = 0;
  int n_fail   = 0;
  beat_t pend_q[$];
  beat_t exp_q[$];
  beat_t got_q[$];

  always #5 clk = ~clk;

  load_align_unit #(.DATA_W(32), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_type(in_type),
    .in_off(in_off), .in_regwr(in_regwr), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_be(out_be),
    .out_rd(out_rd), .out_misalign(out_misalign)
  );

  load_align_unit #(.DATA_W(64), .RD_W(5)) dut_w (
    .clk(clk), .rst_n(rst_n), .flush(w_flush),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data), .in_type(w_in_type),
    .in_off(w_in_off), .in_regwr(w_in_regwr), .in_rd(w_in_rd),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data), .out_be(w_out_be),
    .out_rd(w_out_rd), .out_misalign(w_out_misalign)
  );

  // Byte-list reference: b[0] is the most significant byte of the word.
  function automatic beat_t model(int nb, logic [63:0] d, logic [2:0] t, int k, logic regwr, logic [4:0] rd);
    logic [7:0] b[8];
    logic [7:0] r[8];
    bit         en[8];
    bit         mis;
    logic [7:0] fill;
    beat_t      m;
    mis = 0;
    for (int j = 0; j < 8; j++) begin
      b[j] = (j < nb) ? d[8*(nb-1-j) +: 8] : 8'h00;
      r[j] = b[j];
      en[j] = 1;
    end
    case (t)
      3'd0: for (int j = 0; j < nb; j++) en[j] = regwr;
      3'd1: for (int j = 0; j < nb; j++) begin
        r[j]  = (j + k < nb) ? b[j+k] : 8'h00;
        en[j] = (j < nb - k);
      end
      3'd2: mis = (k != 0);
      3'd3: for (int j = 0; j < nb; j++) begin
        r[j]  = (j >= nb - 1 - k) ? b[j-(nb-1-k)] : 8'h00;
        en[j] = (j >= nb - 1 - k);
      end
      3'd4, 3'd5: begin
        fill = (t == 3'd4 && b[k][7]) ? 8'hFF : 8'h00;
        for (int j = 0; j < nb; j++) r[j] = fill;
        r[nb-1] = b[k];
      end
      default: begin
        if (k % 2 == 1) mis = 1;
        else begin
          fill = (t == 3'd6 && b[k][7]) ? 8'hFF : 8'h00;
          for (int j = 0; j < nb; j++) r[j] = fill;
          r[nb-2] = b[k];
          r[nb-1] = b[k+1];
        end
      end
    endcase
    m = '0;
    for (int j = 0; j < nb; j++) begin
      m.data[8*(nb-1-j) +: 8] = r[j];
      m.be[nb-1-j] = en[j];
    end
    if (mis) begin
      m.data = d;
      m.be   = '0;
    end
    m.mis = mis;
    m.rd = rd;
    m.present = 1'b1;
    return m;
  endfunction

  task automatic rand_beat();
    in_data  = $urandom;
    in_type  = 3'($urandom_range(0, 7));
    in_off   = 2'($urandom_range(0, 3));
    in_regwr = 1'($urandom_range(0, 1));
    in_rd    = 5'($urandom_range(0, 31));
  endtask

  // One clock: sample handshakes at negedge, record transfers, return at posedge+1.
  task automatic cycle(output bit acc);
    beat_t e, g;
    @(negedge clk);
    acc = 0;
    if (flush) pend_q.delete();
    else begin
      if (out_valid && out_ready) begin
        g = '0;
        g.present = 1'b1;
        g.data = {32'h0, out_data};
        g.be = {4'h0, out_be};
        g.rd = out_rd;
        g.mis = out_misalign;
        e = (pend_q.size() > 0) ? pend_q.pop_front() : '0;
        exp_q.push_back(e);
        got_q.push_back(g);
      end
      if (in_valid && in_ready) begin
        pend_q.push_back(model(4, {32'h0, in_data}, in_type, int'(in_off), in_regwr, in_rd));
        acc = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    pend_q.delete();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_checks++; if ({out_data, out_be, out_rd, out_misalign} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got data=%h be=%b rd=%0d mis=%b exp all 0", out_data, out_be, out_rd, out_misalign);
    end
    n_checks++; if ({w_out_valid, w_out_data, w_out_be} !== '0 || w_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_wide got v=%b d=%h be=%h rdy=%b exp 0/0/0/1", w_out_valid, w_out_data, w_out_be, w_in_ready);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  tt[10] = '{3'd1, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6, 3'd2, 3'd7, 3'd0};
    logic [1:0]  tk[10] = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd0, 2'd3};
    logic [31:0] td[10] = '{32'h11223344, 32'h11223344, 32'h11223344, 32'h1122F344, 32'h1122F344,
                            32'h11228344, 32'h11228344, 32'hAABBCCDD, 32'h83441122, 32'hCAFEF00D};
    logic [31:0] ed[10] = '{32'h22334400, 32'h00000011, 32'h11223344, 32'hFFFFFFF3, 32'h000000F3,
                            32'hFFFF8344, 32'h11228344, 32'hAABBCCDD, 32'h00008344, 32'hCAFEF00D};
    logic [3:0]  eb[10] = '{4'hE, 4'h1, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF};
    logic        em[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    beat_t m;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_type = tt[i]; in_off = tk[i]; in_data = td[i]; in_regwr = 1; in_rd = 5'(i + 3);
      out_ready = 1;
      m = model(4, {32'h0, td[i]}, tt[i], int'(tk[i]), 1'b1, 5'(i + 3));
      @(posedge clk); #1;
      in_valid = 0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_latency out_valid got %b exp 1", i, out_valid); end
      n_checks++; if ({out_data, out_be, out_misalign, out_rd} !== {ed[i], eb[i], em[i], 5'(i + 3)}) begin
        n_fail++; $display("FAIL dir%0d got d=%h be=%b mis=%b rd=%0d exp d=%h be=%b mis=%b rd=%0d",
                           i, out_data, out_be, out_misalign, out_rd, ed[i], eb[i], em[i], i + 3);
      end
      n_checks++; if ({32'h0, out_data} !== m.data || {4'h0, out_be} !== m.be || out_misalign !== m.mis) begin
        n_fail++; $display("FAIL dir%0d_model got d=%h be=%b exp d=%h be=%h", i, out_data, out_be, m.data, m.be);
      end
      @(posedge clk); #1;
    end
    out_ready = 0;
  endtask

  task automatic test_back_to_back();
    bit acc;
    clear_q();
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      rand_beat(); in_valid = 1;
      cycle(acc);
      n_checks++; if (out_valid !== 1'b1 || got_q.size() != i) begin
        n_fail++; $display("FAIL b2b_cycle%0d got valid=%b drained=%0d exp valid=1 drained=%0d", i, out_valid, got_q.size(), i);
      end
    end
    in_valid = 0;
    cycle(acc);
    n_checks++; if (got_q.size() != 8 || exp_q.size() != 8) begin
      n_fail++; $display("FAIL b2b_count got %0d exp 8", got_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL b2b_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    out_ready = 0;
  endtask

  task automatic test_backpressure();
    bit acc;
    logic [31:0] held;
    int n_acc;
    clear_q();
    out_ready = 0;
    n_acc = 0;
    for (int i = 0; i < 3; i++) begin
      rand_beat(); in_valid = 1;
      cycle(acc);
      if (acc) n_acc++;
      if (i == 0) held = out_data;
    end
    n_checks++; if (in_ready !== 1'b0 || n_acc != 2) begin
      n_fail++; $display("FAIL bp_full got in_ready=%b accepted=%0d exp 0 and 2", in_ready, n_acc);
    end
    n_checks++; if (out_valid !== 1'b1 || out_data !== held) begin
      n_fail++; $display("FAIL bp_hold got valid=%b data=%h exp 1 and %h", out_valid, out_data, held);
    end
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      cycle(acc);
      if (acc) begin n_acc++; in_valid = 0; end
    end
    n_checks++; if (n_acc != 3 || got_q.size() != 3 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain got accepted=%0d out=%0d valid=%b exp 3 3 0", n_acc, got_q.size(), out_valid);
    end
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL bp_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    in_valid = 0; out_ready = 0;
  endtask

  task automatic test_flush();
    bit acc;
    clear_q();
    out_ready = 0;
    for (int i = 0; i < 2; i++) begin rand_beat(); in_valid = 1; cycle(acc); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_pre_two in_ready got %b exp 0", in_ready); end
    rand_beat(); in_valid = 1; flush = 1;
    cycle(acc);
    flush = 0; in_valid = 0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_state got valid=%b ready=%b exp 0 1", out_valid, in_ready);
    end
    out_ready = 1;
    for (int i = 0; i < 4; i++) cycle(acc);
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL flush_leak got %0d beats exp 0", got_q.size()); end
    out_ready = 0;
  endtask

  task automatic test_random();
    bit acc;
    clear_q();
    for (int c = 0; c < 400; c++) begin
      rand_beat();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      if (flush) out_ready = 0;
      cycle(acc);
    end
    flush = 0; in_valid = 0; out_ready = 1;
    for (int i = 0; i < 4; i++) cycle(acc);
    n_checks++; if (got_q.size() != exp_q.size() || pend_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rand_count got out=%0d pending=%0d valid=%b exp %0d 0 0", got_q.size(), pend_q.size(), out_valid, exp_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rand_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    out_ready = 0;
  endtask

  task automatic test_async_reset();
    bit acc;
    clear_q();
    out_ready = 0;
    for (int i = 0; i < 2; i++) begin rand_beat(); in_data[31] = 1'b1; in_regwr = 1; in_type = 3'd0; in_valid = 1; cycle(acc); end
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    n_checks++; if ({out_valid, out_data, out_be, out_rd, out_misalign} !== '0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL async_reset got v=%b d=%h be=%b rd=%0d mis=%b rdy=%b exp zeros rdy=1",
                         out_valid, out_data, out_be, out_rd, out_misalign, in_ready);
    end
    @(posedge clk); #1 rst_n = 1;
    clear_q();
    out_ready = 1;
    for (int i = 0; i < 3; i++) cycle(acc);
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL reset_drop got %0d beats exp 0", got_q.size()); end
    out_ready = 0;
  endtask

  task automatic test_wide();
    logic [2:0]  tt[4] = '{3'd1, 3'd0, 3'd7, 3'd4};
    logic [2:0]  tk[4] = '{3'd5, 3'd3, 3'd6, 3'd7};
    logic [63:0] ed[4] = '{64'h0607080000000000, 64'h0102030405060708, 64'h0000000000008899, 64'hFFFFFFFFFFFFFFF0};
    logic [7:0]  eb[4] = '{8'hE0, 8'h00, 8'hFF, 8'hFF};
    logic [63:0] src[4] = '{64'h0102030405060708, 64'h0102030405060708, 64'h1122334455668899, 64'h00000000000000F0};
    beat_t m;
    for (int i = 0; i < 4; i++) begin
      w_in_valid = 1; w_in_type = tt[i]; w_in_off = tk[i]; w_in_data = src[i]; w_in_regwr = 0; w_in_rd = 5'd9;
      w_out_ready = 1;
      m = model(8, src[i], tt[i], int'(tk[i]), 1'b0, 5'd9);
      @(posedge clk); #1;
      w_in_valid = 0;
      n_checks++; if (w_out_valid !== 1'b1 || w_out_data !== ed[i] || w_out_be !== eb[i] || w_out_misalign !== 1'b0) begin
        n_fail++; $display("FAIL wide%0d got v=%b d=%h be=%h exp 1 d=%h be=%h", i, w_out_valid, w_out_data, w_out_be, ed[i], eb[i]);
      end
      n_checks++; if (w_out_data !== m.data || w_out_be !== m.be || w_out_rd !== m.rd) begin
        n_fail++; $display("FAIL wide%0d_model got d=%h be=%h exp d=%h be=%h", i, w_out_data, w_out_be, m.data, m.be);
      end
      @(posedge clk); #1;
    end
    w_out_ready = 0;
  endtask

  initial begin
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 0;
    in_data = '0; in_type = '0; in_off = '0; in_regwr = 0; in_rd = '0;
    w_flush = 0; w_in_valid = 0; w_out_ready = 0;
    w_in_data = '0; w_in_type = '0; w_in_off = '0; w_in_regwr = 0; w_in_rd = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_random();
    test_async_reset();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
